decode_regfile_top: RTL and testbench



---
 rtl/rv_pkg.sv | 79 +++++++
 rtl/rv_decoder.sv | 43 ++++
 rtl/rv_regfile.sv | 41 ++++
 rtl/decode_regfile_top.sv | 53 +++++
 tb/tb_decode_regfile_top.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I definitions: widths, opcode/funct encodings and decode records.
package rv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned ILEN     = 32;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_R      = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYS    = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE
  } fmt_e;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_JALR    = 3'b000;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic is_add;
    logic is_sub;
    logic is_addi;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_lui;
    logic is_auipc;
    logic is_jal;
    logic is_jalr;
    logic is_system;
  } instr_flags_t;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [6:0]        funct7;
    fmt_e              fmt;
    instr_flags_t      flags;
    logic              rs1_valid;
    logic              rs2_valid;
  } dec_t;

  // Format class of an opcode; anything unrecognised is FMT_NONE.
  function automatic fmt_e classify(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_R:                             f = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYS: f = FMT_I;
      OP_STORE:                         f = FMT_S;
      OP_BRANCH:                        f = FMT_B;
      OP_LUI, OP_AUIPC:                 f = FMT_U;
      OP_JAL:                           f = FMT_J;
      default:                          f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/rv_decoder.sv
// Combinational RV32I decoder: field split, format class, instruction flags
// and source-operand valid bits.
module rv_decoder
  import rv_pkg::*;
(
  input  logic [ILEN-1:0] instr,
  output dec_t            dec
);

  fmt_e fmt;

  assign fmt = classify(instr[6:0]);

  // Field extraction, flag decode and operand-use qualification.
  always_comb begin
    dec           = '0;
    dec.opcode    = instr[6:0];
    dec.rd        = instr[11:7];
    dec.funct3    = instr[14:12];
    dec.rs1       = instr[19:15];
    dec.rs2       = instr[24:20];
    dec.funct7    = instr[31:25];
    dec.fmt       = fmt;

    dec.flags.is_add    = (instr[6:0] == OP_R) && (instr[14:12] == F3_ADD_SUB)
                          && (instr[31:25] == F7_BASE);
    dec.flags.is_sub    = (instr[6:0] == OP_R) && (instr[14:12] == F3_ADD_SUB)
                          && (instr[31:25] == F7_ALT);
    dec.flags.is_addi   = (instr[6:0] == OP_IMM) && (instr[14:12] == F3_ADD_SUB);
    dec.flags.is_load   = (instr[6:0] == OP_LOAD);
    dec.flags.is_store  = (instr[6:0] == OP_STORE);
    dec.flags.is_branch = (instr[6:0] == OP_BRANCH);
    dec.flags.is_lui    = (instr[6:0] == OP_LUI);
    dec.flags.is_auipc  = (instr[6:0] == OP_AUIPC);
    dec.flags.is_jal    = (instr[6:0] == OP_JAL);
    dec.flags.is_jalr   = (instr[6:0] == OP_JALR) && (instr[14:12] == F3_JALR);
    dec.flags.is_system = (instr[6:0] == OP_SYS);

    dec.rs1_valid = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
    dec.rs2_valid = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
  end

endmodule

// File: rtl/rv_regfile.sv
// Integer register file: two asynchronous read ports, one synchronous write
// port, x0 hardwired to zero, asynchronous active-high reset.
module rv_regfile #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  // x0 has no storage; entries 1..NUM_REGS-1 only.
  logic [XLEN-1:0] regs [1:NUM_REGS-1];

  // Reset clears every stored register; otherwise commit non-x0 writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Zero-latency reads with x0 forced to zero; no write bypass.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != '0) rs1_data = regs[rs1_addr];
    if (rs2_addr != '0) rs2_data = regs[rs2_addr];
  end

endmodule

// File: rtl/decode_regfile_top.sv
// Decode + register-file front end: the decoder selects the source registers
// and the operands are zeroed when the instruction format does not use them.
module decode_regfile_top
  import rv_pkg::*;
#(
  parameter int unsigned XLEN     = rv_pkg::XLEN,
  parameter int unsigned NUM_REGS = rv_pkg::NUM_REGS
) (
  input  logic [31:0]                   instr,
  input  logic                          clk,
  input  logic                          rst,
  output logic [XLEN-1:0]               rs1_read_data,
  output logic [XLEN-1:0]               rs2_read_data,
  input  logic                          rf_write_en,
  input  logic [$clog2(NUM_REGS)-1:0]   rf_write_reg,
  input  logic [XLEN-1:0]               rf_write_data
);

  dec_t            dec;
  logic [XLEN-1:0] rf_rs1;
  logic [XLEN-1:0] rf_rs2;
  logic            dec_unused;

  rv_decoder u_dec (
    .instr (instr),
    .dec   (dec)
  );

  rv_regfile #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (dec.rs1),
    .rs2_addr (dec.rs2),
    .rs1_data (rf_rs1),
    .rs2_data (rf_rs2),
    .we       (rf_write_en),
    .waddr    (rf_write_reg),
    .wdata    (rf_write_data)
  );

  // Decode outputs not consumed at this level (later pipeline stages use them).
  assign dec_unused = ^{dec.opcode, dec.rd, dec.funct3, dec.funct7, dec.fmt, dec.flags};

  // Operand gating by format.
  always_comb begin
    rs1_read_data = dec.rs1_valid ? rf_rs1 : '0;
    rs2_read_data = dec.rs2_valid ? rf_rs2 : '0;
  end

endmodule

// File: tb/tb_decode_regfile_top.sv
// Self-checking bench for decode_regfile_top: directed sequences, a vector
// table for format gating, a full read sweep and randomized traffic against
// an array-based register model.
module tb_decode_regfile_top;

  logic [31:0] instr;
  logic        clk;
  logic        rst;
  logic [31:0] rs1_read_data;
  logic [31:0] rs2_read_data;
  logic        rf_write_en;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] model [32];

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs[$];

  decode_regfile_top #(.XLEN(32), .NUM_REGS(32)) dut (
    .instr         (instr),
    .clk           (clk),
    .rst           (rst),
    .rs1_read_data (rs1_read_data),
    .rs2_read_data (rs2_read_data),
    .rf_write_en   (rf_write_en),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] r2,
                                     input logic [4:0] r1, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] op);
    return {f7, r2, r1, f3, rd, op};
  endfunction

  // Reference read: which operands an opcode uses, looked up in the model.
  function automatic logic [31:0] ref_read(input logic [31:0] ins, input bit second);
    bit use1;
    bit use2;
    logic [4:0] idx;
    use1 = 0;
    use2 = 0;
    case (ins[6:0])
      7'b0110011, 7'b0100011, 7'b1100011:             begin use1 = 1; use2 = 1; end
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: use1 = 1;
      default: ;
    endcase
    idx = second ? ins[24:20] : ins[19:15];
    if (idx == 5'd0) return 32'd0;
    if (second) return use2 ? model[idx] : 32'd0;
    return use1 ? model[idx] : 32'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_model(input string name);
    check({name, " rs1"}, rs1_read_data, ref_read(instr, 1'b0));
    check({name, " rs2"}, rs2_read_data, ref_read(instr, 1'b1));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  // One write cycle: drive at negedge, commit at posedge, release after.
  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    @(negedge clk);
    rf_write_en   = 1'b1;
    rf_write_reg  = r;
    rf_write_data = d;
    @(posedge clk);
    if (r != 5'd0) model[r] = d;
    #1;
    rf_write_en = 1'b0;
  endtask

  task automatic add_vec(input string n, input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] b);
    vec_t v;
    v.name = n; v.instr = i; v.e1 = a; v.e2 = b;
    vecs.push_back(v);
  endtask

  initial begin
    logic [6:0] ops [12];
    clear_model();
    instr         = 32'd0;
    rf_write_en   = 1'b0;
    rf_write_reg  = 5'd0;
    rf_write_data = 32'd0;
    rst           = 1'b0;
    #1 rst = 1'b1;

    // Reset state
    instr = mk(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011);
    #3;
    check("reset x1", rs1_read_data, 32'd0);
    check("reset x2", rs2_read_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous mid-cycle reset after loading x1/x2
    wr(5'd1, 32'h1111_0001);
    wr(5'd2, 32'h2222_0002);
    @(negedge clk);
    #1;
    check("pre-pulse x1", rs1_read_data, 32'h1111_0001);
    check("pre-pulse x2", rs2_read_data, 32'h2222_0002);
    #1 rst = 1'b1;
    #1;
    check("async rst x1", rs1_read_data, 32'd0);
    check("async rst x2", rs2_read_data, 32'd0);
    rst = 1'b0;
    clear_model();

    // Preload: x0 write is discarded
    wr(5'd0, 32'd10);
    wr(5'd1, 32'd15);
    instr = mk(7'd0, 5'd0, 5'd1, 3'd0, 5'd0, 7'b0110011);
    #1;
    check("preload x1", rs1_read_data, 32'd15);
    check("preload x0", rs2_read_data, 32'd0);

    // Read-after-write timing on x5
    @(negedge clk);
    instr         = mk(7'd0, 5'd0, 5'd5, 3'd0, 5'd1, 7'b0110011);
    rf_write_en   = 1'b1;
    rf_write_reg  = 5'd5;
    rf_write_data = 32'hDEADBEEF;
    #1;
    check("raw before edge", rs1_read_data, 32'd0);
    @(posedge clk);
    #1;
    check("raw after edge", rs1_read_data, 32'hDEADBEEF);
    rf_write_en = 1'b0;
    model[5] = 32'hDEADBEEF;

    // Format gating table (x1=15, x2=99, x5=DEADBEEF)
    wr(5'd2, 32'd99);
    add_vec("add",        mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011), 32'd15, 32'd99);
    add_vec("sub",        mk(7'h20, 5'd5, 5'd2, 3'd0, 5'd3, 7'b0110011), 32'd99, 32'hDEADBEEF);
    add_vec("addi x1,rs2f=x2", mk(7'h07, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0010011), 32'd15, 32'd0);
    add_vec("load",       mk(7'h00, 5'd1, 5'd2, 3'd2, 5'd4, 7'b0000011), 32'd99, 32'd0);
    add_vec("store",      mk(7'h00, 5'd2, 5'd1, 3'd2, 5'd0, 7'b0100011), 32'd15, 32'd99);
    add_vec("branch",     mk(7'h00, 5'd5, 5'd1, 3'd1, 5'd0, 7'b1100011), 32'd15, 32'hDEADBEEF);
    add_vec("lui",        mk(7'h7f, 5'd2, 5'd1, 3'd7, 5'd3, 7'b0110111), 32'd0, 32'd0);
    add_vec("auipc",      mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0010111), 32'd0, 32'd0);
    add_vec("jal",        mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'b1101111), 32'd0, 32'd0);
    add_vec("jalr",       mk(7'h00, 5'd1, 5'd2, 3'd0, 5'd3, 7'b1100111), 32'd99, 32'd0);
    add_vec("system",     mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'b1110011), 32'd15, 32'd0);
    add_vec("unknown 00", mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0000000), 32'd0, 32'd0);
    add_vec("unknown 7f", mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'b1111111), 32'd0, 32'd0);
    add_vec("r x0,x0",    mk(7'h00, 5'd0, 5'd0, 3'd0, 5'd3, 7'b0110011), 32'd0, 32'd0);
    foreach (vecs[k]) begin
      instr = vecs[k].instr;
      #1;
      check({vecs[k].name, " rs1"}, rs1_read_data, vecs[k].e1);
      check({vecs[k].name, " rs2"}, rs2_read_data, vecs[k].e2);
    end

    // Write with we=0 has no effect
    @(negedge clk);
    rf_write_en   = 1'b0;
    rf_write_reg  = 5'd7;
    rf_write_data = 32'd55;
    @(posedge clk);
    #1;
    instr = mk(7'd0, 5'd7, 5'd7, 3'd0, 5'd1, 7'b0110011);
    #1;
    check("we=0 x7", rs1_read_data, 32'd0);

    // Reset coinciding with a write edge; writes resume at the first free edge
    @(negedge clk);
    rf_write_en   = 1'b1;
    rf_write_reg  = 5'd9;
    rf_write_data = 32'd123;
    rst           = 1'b1;
    @(posedge clk);
    #1;
    instr = mk(7'd0, 5'd1, 5'd9, 3'd0, 5'd1, 7'b0110011);
    #1;
    check("rst-edge x9", rs1_read_data, 32'd0);
    check("rst-edge x1", rs2_read_data, 32'd0);
    @(negedge clk);
    rst           = 1'b0;
    rf_write_reg  = 5'd4;
    rf_write_data = 32'd77;
    instr = mk(7'd0, 5'd5, 5'd4, 3'd0, 5'd1, 7'b0110011);
    #1;
    check("post-rst x4 old", rs1_read_data, 32'd0);
    check("post-rst x5", rs2_read_data, 32'd0);
    @(posedge clk);
    #1;
    check("resume x4", rs1_read_data, 32'd77);
    rf_write_en = 1'b0;
    clear_model();
    model[4] = 32'd77;

    // All-registers sweep
    for (int i = 1; i < 32; i++) wr(i[4:0], i * 3);
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        instr = mk(7'd0, b[4:0], a[4:0], 3'd0, 5'd1, 7'b0110011);
        #1;
        check($sformatf("sweep rs1 x%0d", a), rs1_read_data, a * 3);
        check($sformatf("sweep rs2 x%0d", b), rs2_read_data, b * 3);
      end
    end

    // Randomized traffic against the model
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0000000, 7'b1011011};
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      instr         = {$urandom()} ;
      instr[6:0]    = ops[$urandom_range(0, 11)];
      rf_write_en   = ($urandom_range(0, 1) == 1);
      rf_write_reg  = 5'($urandom_range(0, 31));
      rf_write_data = $urandom();
      #1;
      check_model($sformatf("rand %0d", n));
      if ($urandom_range(0, 39) == 0) begin
        #1 rst = 1'b1;
        #1;
        clear_model();
        check_model($sformatf("rand rst %0d", n));
        rst = 1'b0;
      end
      @(posedge clk);
      if (rf_write_en && rf_write_reg != 5'd0) model[rf_write_reg] = rf_write_data;
    end
    @(negedge clk);
    rf_write_en = 1'b0;
    #1;
    check_model("rand final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
